// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared state type, default sizes and one-hot decode helper
package apb_slave_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;
  localparam int DEF_NUM_SLOTS = 3;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_ADDR_LSB = 2;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_SLOTS = 32;
  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } onehot_t;
  function automatic onehot_t onehot_idx(input logic [MAX_SLOTS-1:0] sel);
    onehot_t r;
    r.valid = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    r.idx = '0;
    for (int i = 0; i < MAX_SLOTS; i++) if (sel[i]) r.idx = 5'(i);
    return r;
  endfunction
endpackage

// File: rtl/apb_slave_bank_if.sv
// apb_slave_bank_if: APB bus between bridge (master) and register bank (slave)
interface apb_slave_bank_if #(parameter int NUM_SLOTS = apb_slave_pkg::DEF_NUM_SLOTS);
  logic [NUM_SLOTS-1:0] Pselx;
  logic                 Penable;
  logic                 Pwrite;
  logic [31:0]          Paddr;
  logic [31:0]          Pwdata;
  logic [31:0]          Prdata;
  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata);
  modport slave (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata);
endinterface

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: DEPTH x 32 register array, one write port, one async read port
module apb_reg_bank #(
  parameter int DEPTH = apb_slave_pkg::DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [31:0]              rdata
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  // next array contents: current words with the single write applied
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx] = wdata;
  end
  // whole array clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else mem_q <= mem_d;
  end
  assign rdata = mem_q[ridx];
endmodule

// File: rtl/apb_slave_bank.sv
// apb_slave_bank: APB completer with per-select register banks, protocol checking and transfer counters
module apb_slave_bank
  import apb_slave_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_LSB  = DEF_ADDR_LSB,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 Hclk,
  input  logic                 Hresetn,
  apb_slave_bank_if.slave      bus,
  input  logic                 err_clr,
  output logic                 proto_err,
  output logic [CNT_W-1:0]     wr_count,
  output logic [CNT_W-1:0]     rd_count,
  output logic [1:0]           fsm_state
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_SETUP = 2'(SETUP);
  localparam logic [1:0] S_ACCESS = 2'(ACCESS);
  logic [1:0]           state_q, state_d;
  logic [NUM_SLOTS-1:0] sel_q, sel_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4:0]           bidx_q, bidx_d;
  logic                 ok_q, ok_d;
  logic                 wr_q, wr_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          prdata_q, prdata_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [31:0]          rdata [NUM_SLOTS];
  logic [31:0]          rd_mux;
  logic [IW-1:0]        cur_idx;
  onehot_t              oh;
  logic                 setup, access, match, latch, commit, viol;
  // read data of the currently selected bank; OR-mux is exact when select is one-hot
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLOTS; i++) if (bus.Pselx[i]) rd_mux = rd_mux | rdata[i];
  end
  // transfer sequencing, violation detection and next-state of all registers
  always_comb begin
    cur_idx = bus.Paddr[ADDR_LSB +: IW];
    oh = onehot_idx(MAX_SLOTS'(bus.Pselx));
    setup = |bus.Pselx && !bus.Penable;
    access = |bus.Pselx && bus.Penable;
    match = bus.Pselx == sel_q && bus.Paddr == addr_q && bus.Pwrite == wr_q;
    latch = 1'b0;
    commit = 1'b0;
    viol = 1'b0;
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: if (setup) latch = 1'b1; else viol = bus.Penable;
      S_SETUP:
        if (access && match) begin
          state_d = S_ACCESS;
          commit = ok_q;
        end else begin
          viol = 1'b1;
          latch = setup;
        end
      S_ACCESS: if (setup) latch = 1'b1; else viol = bus.Penable && bus.Pselx == sel_q;
      default: ;
    endcase
    if (latch) begin
      state_d = S_SETUP;
      viol = viol || !oh.valid;
    end
    sel_d = latch ? bus.Pselx : sel_q;
    idx_d = latch ? cur_idx : idx_q;
    bidx_d = latch ? oh.idx : bidx_q;
    ok_d = latch ? oh.valid : ok_q;
    wr_d = latch ? bus.Pwrite : wr_q;
    addr_d = latch ? bus.Paddr : addr_q;
    prdata_d = !latch ? prdata_q : !oh.valid ? '0 : bus.Pwrite ? prdata_q : rd_mux;
    wcnt_d = (commit && wr_q && !(&wcnt_q)) ? wcnt_q + 1'b1 : wcnt_q;
    rcnt_d = (commit && !wr_q && !(&rcnt_q)) ? rcnt_q + 1'b1 : rcnt_q;
    err_d = viol || (err_q && !err_clr);
  end
  // state and datapath registers
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= S_IDLE;
      sel_q <= '0;
      idx_q <= '0;
      bidx_q <= '0;
      ok_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      prdata_q <= '0;
      err_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      idx_q <= idx_d;
      bidx_q <= bidx_d;
      ok_q <= ok_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      prdata_q <= prdata_d;
      err_q <= err_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_bank
    apb_reg_bank #(.DEPTH(DEPTH)) u_bank (
      .clk(Hclk),
      .rst_n(Hresetn),
      .we(commit && wr_q && bidx_q == 5'(i)),
      .widx(idx_q),
      .wdata(bus.Pwdata),
      .ridx(cur_idx),
      .rdata(rdata[i])
    );
  end
  assign bus.Prdata = prdata_q;
  assign proto_err = err_q;
  assign wr_count = wcnt_q;
  assign rd_count = rcnt_q;
  assign fsm_state = state_q;
endmodule

// File: tb/tb_apb_slave_bank.sv
// tb_apb_slave_bank: directed and random APB traffic checked against a transfer-level model
module tb_apb_slave_bank;
  localparam int NS = 3;
  localparam int DEPTH = 16;
  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b1;
  logic        err_clr = 1'b0;
  logic        proto_err;
  logic [15:0] wr_count, rd_count;
  logic [1:0]  fsm_state;
  int          tests = 0;
  int          fails = 0;
  bit          started = 1'b0;

  apb_slave_bank_if #(.NUM_SLOTS(NS)) bus ();

  apb_slave_bank #(.NUM_SLOTS(NS), .DEPTH(DEPTH), .ADDR_LSB(2), .CNT_W(16)) dut (
    .Hclk(Hclk),
    .Hresetn(Hresetn),
    .bus(bus),
    .err_clr(err_clr),
    .proto_err(proto_err),
    .wr_count(wr_count),
    .rd_count(rd_count),
    .fsm_state(fsm_state)
  );

  always #5 Hclk = ~Hclk;

  logic [31:0] mem [NS][DEPTH];
  int          m_ph;
  logic [NS-1:0] m_sel;
  logic [31:0] m_addr, m_prdata;
  bit          m_wr, m_err;
  int          m_wc, m_rc;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int bank_of(input logic [NS-1:0] s);
    for (int i = 0; i < NS; i++) if (s[i]) return i;
    return 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic model_reset();
    m_ph = 0; m_sel = '0; m_addr = '0; m_prdata = '0; m_wr = 0; m_err = 0; m_wc = 0; m_rc = 0;
    for (int b = 0; b < NS; b++) for (int w = 0; w < DEPTH; w++) mem[b][w] = '0;
  endtask

  task automatic model_step();
    logic [NS-1:0] s;
    bit en, su, ac, viol, lat;
    int nph;
    s = bus.Pselx; en = bus.Penable;
    su = s != 0 && !en; ac = s != 0 && en;
    viol = 0; lat = 0; nph = 0;
    if (m_ph == 0) begin
      if (su) lat = 1; else if (en) viol = 1;
    end else if (m_ph == 1) begin
      if (ac && s == m_sel && bus.Paddr == m_addr && bus.Pwrite == m_wr) begin
        nph = 2;
        if ($countones(m_sel) == 1) begin
          if (m_wr) begin
            mem[bank_of(m_sel)][widx(m_addr)] = bus.Pwdata;
            if (m_wc < 65535) m_wc++;
          end else if (m_rc < 65535) m_rc++;
        end
      end else begin
        viol = 1; lat = su;
      end
    end else begin
      if (su) lat = 1; else if (en && s == m_sel) viol = 1;
    end
    if (lat) begin
      nph = 1; m_sel = s; m_addr = bus.Paddr; m_wr = bus.Pwrite;
      if ($countones(s) != 1) begin
        viol = 1; m_prdata = '0;
      end else if (!bus.Pwrite) m_prdata = mem[bank_of(s)][widx(bus.Paddr)];
    end
    m_err = viol || (m_err && !err_clr);
    m_ph = nph;
  endtask

  initial forever begin
    @(posedge Hclk or negedge Hresetn);
    if (!Hresetn) model_reset(); else model_step();
  end

  initial forever begin
    @(negedge Hclk);
    if (started) begin
      chk("fsm_state", 32'(fsm_state), 32'(m_ph));
      chk("Prdata", bus.Prdata, m_prdata);
      chk("proto_err", 32'(proto_err), 32'(m_err));
      chk("wr_count", 32'(wr_count), 32'(m_wc));
      chk("rd_count", 32'(rd_count), 32'(m_rc));
    end
  end

  task automatic idle_cyc();
    @(negedge Hclk);
    bus.Pselx = '0; bus.Penable = 0;
  endtask

  task automatic xfer(input logic [NS-1:0] s, input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge Hclk);
    bus.Pselx = s; bus.Penable = 0; bus.Pwrite = w; bus.Paddr = a; bus.Pwdata = d;
    @(negedge Hclk);
    bus.Penable = 1;
  endtask

  task automatic clear_err();
    @(negedge Hclk);
    bus.Pselx = '0; bus.Penable = 0; err_clr = 1;
    @(negedge Hclk);
    err_clr = 0;
  endtask

  initial begin
    logic [NS-1:0] s;
    logic [31:0] a;
    int r;
    bus.Pselx = '0; bus.Penable = 0; bus.Pwrite = 0; bus.Paddr = '0; bus.Pwdata = '0;
    #1 Hresetn = 0;
    started = 1;
    repeat (3) @(negedge Hclk);
    chk("rst_fsm", 32'(fsm_state), 32'd0);
    chk("rst_prdata", bus.Prdata, 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    chk("rst_wr", 32'(wr_count), 32'd0);
    chk("rst_rd", 32'(rd_count), 32'd0);
    Hresetn = 1;

    xfer(3'b001, 1, 32'h8000_0004, 32'hDEAD_BEEF);
    xfer(3'b001, 0, 32'h8000_0004, 32'h0);
    chk("rd_back", bus.Prdata, 32'hDEAD_BEEF);
    chk("wr_cnt1", 32'(wr_count), 32'd1);
    idle_cyc();
    chk("rd_cnt1", 32'(rd_count), 32'd1);
    chk("rd_hold", bus.Prdata, 32'hDEAD_BEEF);

    xfer(3'b001, 1, 32'h8000_000C, 32'h1111_1111);
    xfer(3'b010, 0, 32'h8000_000C, 32'h0);
    chk("bank_indep", bus.Prdata, 32'h0);

    xfer(3'b001, 1, 32'h8000_0044, 32'hCAFE_0001);
    xfer(3'b001, 0, 32'h8000_0004, 32'h0);
    chk("idx_wrap", bus.Prdata, 32'hCAFE_0001);
    idle_cyc();

    @(negedge Hclk);
    bus.Pselx = '0; bus.Penable = 1;
    idle_cyc();
    chk("idle_penable_err", 32'(proto_err), 32'd1);
    clear_err();
    chk("err_clr", 32'(proto_err), 32'd0);
    xfer(3'b011, 1, 32'h0, 32'h1234_5678);
    idle_cyc();
    chk("multi_sel_err", 32'(proto_err), 32'd1);
    chk("multi_sel_wr", 32'(wr_count), 32'd3);
    xfer(3'b010, 0, 32'h0, 32'h0);
    chk("multi_sel_nowrite", bus.Prdata, 32'h0);
    clear_err();

    @(negedge Hclk);
    bus.Pselx = 3'b001; bus.Penable = 0; bus.Pwrite = 1; bus.Paddr = 32'hC; bus.Pwdata = 32'h5555_5555;
    @(negedge Hclk);
    bus.Penable = 1; bus.Paddr = 32'h8;
    @(negedge Hclk);
    chk("addr_chg_idle", 32'(fsm_state), 32'd0);
    chk("addr_chg_err", 32'(proto_err), 32'd1);
    bus.Pselx = '0; bus.Penable = 0;
    xfer(3'b001, 0, 32'hC, 32'h0);
    chk("addr_chg_nowrite", bus.Prdata, 32'h1111_1111);
    xfer(3'b001, 0, 32'h8, 32'h0);
    chk("addr_chg_nowrite8", bus.Prdata, 32'h0);
    clear_err();

    @(negedge Hclk);
    bus.Pselx = 3'b001; bus.Penable = 0; bus.Pwrite = 1; bus.Paddr = 32'h10; bus.Pwdata = 32'hAAAA_AAAA;
    @(negedge Hclk);
    bus.Penable = 1;
    @(posedge Hclk);
    #2 Hresetn = 0;
    #1;
    chk("mid_rst_fsm", 32'(fsm_state), 32'd0);
    chk("mid_rst_prdata", bus.Prdata, 32'd0);
    chk("mid_rst_wr", 32'(wr_count), 32'd0);
    chk("mid_rst_rd", 32'(rd_count), 32'd0);
    @(negedge Hclk);
    bus.Pselx = '0; bus.Penable = 0; Hresetn = 1;
    xfer(3'b001, 0, 32'h10, 32'h0);
    chk("mid_rst_bank10", bus.Prdata, 32'h0);
    xfer(3'b001, 0, 32'h8000_0004, 32'h0);
    chk("mid_rst_bank4", bus.Prdata, 32'h0);
    idle_cyc();
    chk("mid_rst_wr_after", 32'(wr_count), 32'd0);
    chk("mid_rst_rd_after", 32'(rd_count), 32'd2);

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      err_clr = ($urandom_range(0, 9) == 0);
      a = ($urandom() & ~32'h3C) | (32'($urandom_range(0, 3)) << 2);
      if (r < 7) begin
        s = NS'(1 << $urandom_range(0, NS - 1));
        xfer(s, 1'($urandom()), a, $urandom());
      end else if (r == 7) begin
        s = NS'($urandom());
        xfer(s, 1'($urandom()), a, $urandom());
      end else begin
        @(negedge Hclk);
        bus.Pselx = NS'($urandom()); bus.Penable = 1'($urandom()); bus.Pwrite = 1'($urandom());
        bus.Paddr = a; bus.Pwdata = $urandom();
      end
    end
    err_clr = 0;
    idle_cyc();
    idle_cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
